// File: rtl/dac_sched_pkg.sv
// Shared definitions for the DAC frame scheduler: FSM state encoding,
// counter widths and the DAC midscale code.
// Build option: DAC_OFFSET_BINARY_EN selects offset-binary DAC coding.
package dac_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_PAYLOAD  = 2'd2,
      ST_GUARD    = 2'd3
   } state_t;

   localparam int PAY_W   = 12;   // payload length / slot counter width
   localparam int GUARD_W = 8;    // guard length width
   localparam int CNT_W   = 12;   // shared per-state slot counter width
   localparam int UNDER_W = 16;   // underrun counter width

`ifdef DAC_OFFSET_BINARY_EN
   localparam logic [13:0] MIDSCALE_CODE = 14'h2000;
`else
   localparam logic [13:0] MIDSCALE_CODE = 14'h0000;
`endif

endpackage

// File: rtl/dac_code_conv.sv
// Output coding stage: converts the selected signed I/Q sample into the DAC
// code and registers it, so a sample chosen in cycle n is on the pins in n+1.
// Build option: DAC_OFFSET_BINARY_EN (MSB-inverted offset binary), otherwise
// raw two's complement.
module dac_code_conv #(
   parameter int DW = 14
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] i_samp_a,
   input  logic [DW-1:0] i_samp_b,
   output logic [DW-1:0] o_dac_a,
   output logic [DW-1:0] o_dac_b
);

   logic [DW-1:0] w_code_a;
   logic [DW-1:0] w_code_b;
   logic [DW-1:0] w_mid;
   logic [DW-1:0] r_dac_a;
   logic [DW-1:0] r_dac_b;

`ifdef DAC_OFFSET_BINARY_EN
   assign w_code_a = {~i_samp_a[DW-1], i_samp_a[DW-2:0]};
   assign w_code_b = {~i_samp_b[DW-1], i_samp_b[DW-2:0]};
   assign w_mid    = {1'b1, {(DW-1){1'b0}}};
`else
   assign w_code_a = i_samp_a;
   assign w_code_b = i_samp_b;
   assign w_mid    = {DW{1'b0}};
`endif

   // Register the coded sample; reset parks both channels at midscale.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dac_a <= w_mid;
         r_dac_b <= w_mid;
      end else begin
         r_dac_a <= w_code_a;
         r_dac_b <= w_code_b;
      end
   end

   assign o_dac_a = r_dac_a;
   assign o_dac_b = r_dac_b;

endmodule

// File: rtl/dac_frame_scheduler.sv
// DAC frame scheduler: on start, plays a fixed +/- preamble, then a payload
// taken one slot per clock from the s_* stream (midscale on underrun), then
// a midscale guard interval, and pulses frame_done on return to IDLE.
// Build option: DAC_OFFSET_BINARY_EN (offset-binary DAC coding, see dac_code_conv).
module dac_frame_scheduler
   import dac_sched_pkg::*;
#(
   parameter int                     DW      = 14,
   parameter int                     PRE_LEN = 32,
   parameter logic signed [DW-1:0]   PRE_AMP = 14'sd4096
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [11:0]   cfg_payload_len,
   input  logic [7:0]    cfg_guard_len,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_i,
   input  logic [DW-1:0] s_q,
   output logic [DW-1:0] dac_a,
   output logic [DW-1:0] dac_b,
   output logic          busy,
   output logic          frame_done,
   output logic [15:0]   underrun_cnt
);

   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_LEN - 1);
   localparam logic [DW-1:0]    AMP_POS  = PRE_AMP;
   localparam logic [DW-1:0]    AMP_NEG  = -PRE_AMP;

   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [PAY_W-1:0]     r_pay_len;
   logic [GUARD_W-1:0]   r_guard_len;
   logic                 r_s_ready;
   logic                 r_busy;
   logic                 r_frame_done;
   logic [UNDER_W-1:0]   r_underrun;

   logic [DW-1:0]        w_sel_i;
   logic [DW-1:0]        w_sel_q;
   logic                 w_pay_last;
   logic                 w_guard_last;

   // Last-slot detection; lengths are known non-zero whenever the state is entered.
   assign w_pay_last   = (r_cnt == (r_pay_len - 12'd1));
   assign w_guard_last = (r_cnt == {{(CNT_W-GUARD_W){1'b0}}, (r_guard_len - 8'd1)});

   // Choose this cycle's I/Q sample from the current state and slot.
   always_comb begin
      w_sel_i = {DW{1'b0}};
      w_sel_q = {DW{1'b0}};
      case (r_state)
         ST_PREAMBLE: begin
            if (r_cnt[0] == 1'b0) begin
               w_sel_i = AMP_POS;
            end else begin
               w_sel_i = AMP_NEG;
            end
         end
         ST_PAYLOAD: begin
            if (s_valid) begin
               w_sel_i = s_i;
               w_sel_q = s_q;
            end else begin
               w_sel_i = {DW{1'b0}};
               w_sel_q = {DW{1'b0}};
            end
         end
         default: begin
            w_sel_i = {DW{1'b0}};
            w_sel_q = {DW{1'b0}};
         end
      endcase
   end

   // Frame FSM with its slot counter, latched lengths and registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= {CNT_W{1'b0}};
         r_pay_len    <= {PAY_W{1'b0}};
         r_guard_len  <= {GUARD_W{1'b0}};
         r_s_ready    <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_underrun   <= {UNDER_W{1'b0}};
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_pay_len   <= cfg_payload_len;
                  r_guard_len <= cfg_guard_len;
                  r_cnt       <= {CNT_W{1'b0}};
                  r_busy      <= 1'b1;
                  r_state     <= ST_PREAMBLE;
               end
            end
            ST_PREAMBLE: begin
               if (r_cnt == PRE_LAST) begin
                  r_cnt <= {CNT_W{1'b0}};
                  if (r_pay_len != 12'd0) begin
                     r_s_ready <= 1'b1;
                     r_state   <= ST_PAYLOAD;
                  end else if (r_guard_len != 8'd0) begin
                     r_state <= ST_GUARD;
                  end else begin
                     r_busy       <= 1'b0;
                     r_frame_done <= 1'b1;
                     r_state      <= ST_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 12'd1;
               end
            end
            ST_PAYLOAD: begin
               if (!s_valid && (r_underrun != 16'hFFFF)) begin
                  r_underrun <= r_underrun + 16'd1;
               end
               if (w_pay_last) begin
                  r_cnt     <= {CNT_W{1'b0}};
                  r_s_ready <= 1'b0;
                  if (r_guard_len != 8'd0) begin
                     r_state <= ST_GUARD;
                  end else begin
                     r_busy       <= 1'b0;
                     r_frame_done <= 1'b1;
                     r_state      <= ST_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 12'd1;
               end
            end
            ST_GUARD: begin
               if (w_guard_last) begin
                  r_cnt        <= {CNT_W{1'b0}};
                  r_busy       <= 1'b0;
                  r_frame_done <= 1'b1;
                  r_state      <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 12'd1;
               end
            end
            default: begin
               r_cnt     <= {CNT_W{1'b0}};
               r_s_ready <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   dac_code_conv #(.DW(DW)) u_conv (
      .clk      (clk),
      .reset    (reset),
      .i_samp_a (w_sel_i),
      .i_samp_b (w_sel_q),
      .o_dac_a  (dac_a),
      .o_dac_b  (dac_b)
   );

   assign s_ready      = r_s_ready;
   assign busy         = r_busy;
   assign frame_done   = r_frame_done;
   assign underrun_cnt = r_underrun;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Scoreboard bench for dac_frame_scheduler: the stimulus process derives each
// frame's expected DAC sample stream from the frame rules and queues it; a
// negedge monitor pops one entry per busy cycle and compares the DAC pins.
module tb_dac_frame_scheduler;

   localparam int PRE_LEN = 32;

`ifdef DAC_OFFSET_BINARY_EN
   localparam logic [13:0] MID = 14'h2000;
`else
   localparam logic [13:0] MID = 14'h0000;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [11:0] cfg_payload_len = 12'd0;
   logic [7:0]  cfg_guard_len = 8'd0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [13:0] s_i = 14'd0;
   logic [13:0] s_q = 14'd0;
   logic [13:0] dac_a;
   logic [13:0] dac_b;
   logic        busy;
   logic        frame_done;
   logic [15:0] underrun_cnt;

   int checks = 0;
   int errors = 0;
   int exp_done = 0;
   int done_seen = 0;
   int model_under = 0;
   logic [27:0] exp_q[$];
   logic prev_busy = 1'b0;
   logic prev_reset = 1'b1;

   dac_frame_scheduler dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .cfg_payload_len (cfg_payload_len),
      .cfg_guard_len   (cfg_guard_len),
      .s_valid         (s_valid),
      .s_ready         (s_ready),
      .s_i             (s_i),
      .s_q             (s_q),
      .dac_a           (dac_a),
      .dac_b           (dac_b),
      .busy            (busy),
      .frame_done      (frame_done),
      .underrun_cnt    (underrun_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [13:0] code(input logic [13:0] x);
`ifdef DAC_OFFSET_BINARY_EN
      return x ^ 14'h2000;
`else
      return x;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: one expected sample per cycle that followed a busy cycle.
   always @(negedge clk) begin
      logic [27:0] e;
      if (prev_reset) begin
         exp_q.delete();
         chk("reset_dac", {18'd0, dac_a}, {18'd0, MID});
         chk("reset_dacb", {18'd0, dac_b}, {18'd0, MID});
      end else if (prev_busy) begin
         if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("frame_sample", {4'd0, dac_a, dac_b}, {4'd0, e});
         end
      end else begin
         chk("idle_dac", {4'd0, dac_a, dac_b}, {4'd0, MID, MID});
      end
      if (frame_done) done_seen++;
      prev_busy  = busy;
      prev_reset = reset;
   end

   // vmode: 0 all valid, 1 random valid, 2 slot t invalid when vmask[t] set.
   task automatic run_frame(input int pay, input int guard, input int vmode,
                            input logic [31:0] vmask, input int restart_slot,
                            input int abort_slot);
      logic        v;
      logic [13:0] si;
      logic [13:0] sq;
      logic [13:0] amp;
      start = 1'b1;
      cfg_payload_len = 12'(pay);
      cfg_guard_len   = 8'(guard);
      tick();
      start = 1'b0;
      cfg_payload_len = 12'($urandom);
      cfg_guard_len   = 8'($urandom);
      for (int t = 0; t < PRE_LEN; t++) begin
         chk("pre_busy", {31'd0, busy}, 32'd1);
         chk("pre_ready", {31'd0, s_ready}, 32'd0);
         amp = (t % 2 == 0) ? 14'd4096 : 14'h3000;
         exp_q.push_back({code(amp), code(14'd0)});
         s_valid = 1'($urandom);
         s_i = 14'($urandom);
         tick();
      end
      for (int t = 0; t < pay; t++) begin
         chk("pay_busy", {31'd0, busy}, 32'd1);
         chk("pay_ready", {31'd0, s_ready}, 32'd1);
         if (vmode == 0)      v = 1'b1;
         else if (vmode == 1) v = ($urandom_range(0, 3) != 0);
         else                 v = !vmask[t];
         si = 14'($urandom);
         sq = 14'($urandom);
         s_valid = v;
         s_i = si;
         s_q = sq;
         start = (t == restart_slot);
         if (t == abort_slot) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            s_valid = 1'b0;
            start = 1'b0;
            model_under = 0;
            chk("abort_busy", {31'd0, busy}, 32'd0);
            chk("abort_ready", {31'd0, s_ready}, 32'd0);
            chk("abort_done", {31'd0, frame_done}, 32'd0);
            chk("abort_under", {16'd0, underrun_cnt}, 32'd0);
            chk("abort_dac", {4'd0, dac_a, dac_b}, {4'd0, MID, MID});
            return;
         end
         if (v) exp_q.push_back({code(si), code(sq)});
         else   exp_q.push_back({MID, MID});
         if (!v && model_under < 65535) model_under++;
         tick();
      end
      start = 1'b0;
      for (int t = 0; t < guard; t++) begin
         chk("guard_busy", {31'd0, busy}, 32'd1);
         chk("guard_ready", {31'd0, s_ready}, 32'd0);
         exp_q.push_back({MID, MID});
         s_valid = 1'($urandom);
         tick();
      end
      s_valid = 1'b0;
      exp_done++;
      chk("end_busy", {31'd0, busy}, 32'd0);
      chk("end_done", {31'd0, frame_done}, 32'd1);
      chk("end_ready", {31'd0, s_ready}, 32'd0);
      chk("end_under", {16'd0, underrun_cnt}, 32'(model_under));
      tick();
      chk("done_pulse", {31'd0, frame_done}, 32'd0);
   endtask

   initial begin
      tick();
      tick();
      reset = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, s_ready}, 32'd0);
      chk("rst_done", {31'd0, frame_done}, 32'd0);
      chk("rst_under", {16'd0, underrun_cnt}, 32'd0);
      tick();
      // 4 payload, 2 guard, all valid
      run_frame(4, 2, 0, 32'd0, -1, -1);
      // 8 payload with 3 missing slots
      run_frame(8, 2, 2, 32'h0000_0052, -1, -1);
      chk("under_three", {16'd0, underrun_cnt}, 32'd3);
      // empty payload and guard
      run_frame(0, 0, 0, 32'd0, -1, -1);
      // payload only, no guard
      run_frame(3, 0, 0, 32'd0, -1, -1);
      // restart request during payload is ignored
      run_frame(6, 1, 0, 32'd0, 2, -1);
      // empty payload with guard
      run_frame(0, 3, 0, 32'd0, -1, -1);
      // random frames
      for (int k = 0; k < 6; k++) begin
         run_frame($urandom_range(0, 20), $urandom_range(0, 5), 1, 32'd0, -1, -1);
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      end
      // reset mid-payload after some underruns
      run_frame(10, 2, 2, 32'h0000_0003, -1, 4);
      tick();
      tick();
      run_frame(5, 1, 1, 32'd0, -1, -1);
      tick();
      tick();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("frame_done_count", 32'(done_seen), 32'(exp_done));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
